// File: rtl/nap_tx_arbiter_pkg.sv
// Shared types and limits for the NAP tx arbiter: arbitration mode encoding
// and the supported requester-count range.
package nap_tx_arbiter_pkg;

  typedef enum logic [0:0] {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_t;

  localparam int NUM_REQ_MIN = 32'sd2;
  localparam int NUM_REQ_MAX = 32'sd16;

  // Map the integer ARB_MODE parameter onto the enum; anything but 1 is round-robin.
  function automatic arb_mode_t mode_from_int(input int mode);
    return (mode == 32'sd1) ? ARB_FIXED : ARB_RR;
  endfunction

endpackage

// File: rtl/nap_tx_arbiter_if.sv
// NAP data-stream bundle: the arbiter drives data/addr/valid, the NAP returns ready.
interface nap_tx_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic [DATA_W-1:0] data;
  logic [ADDR_W-1:0] addr;
  logic              valid;
  logic              ready;

  modport tx (output data, output addr, output valid, input ready);
  modport rx (input data, input addr, input valid, output ready);
endinterface

// File: rtl/nap_tx_arbiter_rr_pick.sv
// Combinational masked priority picker: scans elig starting one past last_grant
// (round-robin) or from index 0 (fixed), returning the winner as one-hot and index.
module nap_tx_arbiter_rr_pick
  import nap_tx_arbiter_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] elig,
  input  logic [IDX_W-1:0]   last_grant,
  input  arb_mode_t          mode,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   index
);

  logic [IDX_W-1:0] base_s;
  logic [IDX_W:0]   sum_s;
  logic [IDX_W-1:0] pos_s;
  logic             hit_s;
  logic             found_s;

  // Wrapped scan from base; the first eligible position wins.
  always_comb begin
    index   = '0;
    found_s = 1'b0;
    sum_s   = '0;
    pos_s   = '0;
    hit_s   = 1'b0;
    base_s  = (mode == ARB_FIXED || last_grant == IDX_W'(NUM_REQ - 1)) ? '0
                                                                        : last_grant + 1'b1;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum_s   = {1'b0, base_s} + (IDX_W + 1)'(k);
      pos_s   = (sum_s >= (IDX_W + 1)'(NUM_REQ)) ? IDX_W'(sum_s - (IDX_W + 1)'(NUM_REQ))
                                                 : sum_s[IDX_W-1:0];
      hit_s   = !found_s && elig[pos_s];
      index   = hit_s ? pos_s : index;
      found_s = found_s || hit_s;
    end
    onehot = found_s ? (NUM_REQ'(1'b1) << index) : '0;
  end

endmodule

// File: rtl/nap_tx_arbiter.sv
// Shares one NAP tx port among NUM_REQ requesters through a one-deep registered
// output slice; round-robin or fixed-priority selection.
module nap_tx_arbiter
  import nap_tx_arbiter_pkg::*;
#(
  parameter int  NUM_REQ  = 4,
  parameter int  DATA_W   = 8,
  parameter int  ADDR_W   = 4,
  parameter int  ARB_MODE = 0,
  localparam int IDX_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_REQ-1:0]        cfg_enable,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  nap_tx_arbiter_if.tx              nap,
  output logic [IDX_W-1:0]          grant_id,
  output logic                      busy
);

  localparam arb_mode_t MODE = mode_from_int(ARB_MODE);

  if (NUM_REQ < NUM_REQ_MIN || NUM_REQ > NUM_REQ_MAX) begin : g_num_req_check
    $error("nap_tx_arbiter: NUM_REQ out of range");
  end

  logic [DATA_W-1:0]  data_arr_s [NUM_REQ];
  logic [ADDR_W-1:0]  addr_arr_s [NUM_REQ];
  logic [NUM_REQ-1:0] elig_s;
  logic [NUM_REQ-1:0] pick_onehot_s;
  logic [IDX_W-1:0]   pick_idx_s;
  logic               free_s;
  logic               load_s;

  logic               valid_d, valid_q;
  logic [DATA_W-1:0]  data_d,  data_q;
  logic [ADDR_W-1:0]  addr_d,  addr_q;
  logic [IDX_W-1:0]   grant_d, grant_q;
  logic [IDX_W-1:0]   last_d,  last_q;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data_arr_s[i] = req_data[i*DATA_W +: DATA_W];
    assign addr_arr_s[i] = req_addr[i*ADDR_W +: ADDR_W];
  end

  nap_tx_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .elig       (elig_s),
    .last_grant (last_q),
    .mode       (MODE),
    .onehot     (pick_onehot_s),
    .index      (pick_idx_s)
  );

  // Slice control: load the winner when the slice is free, drain when nothing is eligible.
  always_comb begin
    elig_s    = req_valid & cfg_enable;
    free_s    = !valid_q || nap.ready;
    load_s    = free_s && (|elig_s);
    // resetn gate keeps req_ready low while the slice is held in reset.
    req_ready = pick_onehot_s & {NUM_REQ{load_s && resetn}};
    valid_d   = valid_q;
    data_d    = data_q;
    addr_d    = addr_q;
    grant_d   = grant_q;
    last_d    = last_q;
    if (load_s) begin
      valid_d = 1'b1;
      data_d  = data_arr_s[pick_idx_s];
      addr_d  = addr_arr_s[pick_idx_s];
      grant_d = pick_idx_s;
      last_d  = pick_idx_s;
    end else if (free_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Output slice and round-robin pointer registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign nap.valid = valid_q;
  assign nap.data  = data_q;
  assign nap.addr  = addr_q;
  assign grant_id  = grant_q;
  assign busy      = valid_q;

endmodule
